// File: rtl/static_branch_predictor.sv
// Decode-stage static branch predictor with EX-stage verification.
// Conditional branches use backward-taken/forward-not-taken; JAL is always
// taken. Each prediction travels into EX as a record, is checked against the
// ALU outcome there, and drives the mispredict redirect and the counters.
module static_branch_predictor #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidD,
    input  logic [31:0]      InstrD,
    input  logic [31:0]      PCD,
    input  logic [31:0]      ImmExtD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             BranchTakenE,
    input  logic [31:0]      BranchTargetE,
    output logic             PredRedirectD,
    output logic [31:0]      PredTargetD,
    output logic             MispredictE,
    output logic [31:0]      CorrectPCE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Prediction record carried from decode into EX.
    typedef struct packed {
        logic        valid;
        logic        is_branch;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [31:0] pc_plus4;
    } ex_rec_t;

    logic    is_branch_d;
    logic    is_jal_d;
    logic    pred_taken_d;
    ex_rec_t rec_d, rec_q;

    logic             count_en;
    logic [CNT_W-1:0] branch_cnt_d, branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

    // Decode: classify the opcode and form the static prediction.
    always_comb begin
        is_branch_d   = (InstrD[6:0] == OPC_BRANCH);
        is_jal_d      = (InstrD[6:0] == OPC_JAL);
        // A negative offset (sign bit set) means a backward branch: predict taken.
        pred_taken_d  = ValidD & (is_jal_d | (is_branch_d & ImmExtD[31]));
        // The decode slot is wrong-path whenever EX redirects, so EX wins.
        PredRedirectD = pred_taken_d & ~MispredictE;
        PredTargetD   = PCD + ImmExtD;
    end

    // EX check: compare the stored prediction with the resolved outcome.
    always_comb begin
        MispredictE = rec_q.valid & ~StallE &
                      ((BranchTakenE != rec_q.pred_taken) |
                       (BranchTakenE & (BranchTargetE != rec_q.pred_target)));
        CorrectPCE  = BranchTakenE ? BranchTargetE : rec_q.pc_plus4;
    end

    // Next EX record: squash on redirect/bubble, hold on stall, else load.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        rec_d = rec_q;
        if (MispredictE || FlushE) begin
            rec_d.valid = 1'b0;
        end else if (!StallE) begin
            rec_d.valid       = ValidD & (is_branch_d | is_jal_d);
            rec_d.is_branch   = is_branch_d;
            rec_d.pred_taken  = pred_taken_d;
            rec_d.pred_target = PredTargetD;
            rec_d.pc_plus4    = PCD + 32'd4;
        end
    end

    // Saturating counter updates for resolved conditional branches only.
    always_comb begin
        count_en      = rec_q.valid & rec_q.is_branch & ~StallE;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (count_en) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
            if (MispredictE && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    // State registers: EX record and counters, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rec_q         <= rec_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_static_branch_predictor.sv
// Directed self-checking bench for static_branch_predictor (CNT_W = 4 build
// so counter saturation is reachable in a few cycles).
module tb_static_branch_predictor;

    localparam int CNT_W = 4;

    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_BNE  = 32'h00001863;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_JALR = 32'h00008067;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ValidD;
    logic [31:0]      InstrD;
    logic [31:0]      PCD;
    logic [31:0]      ImmExtD;
    logic             StallE;
    logic             FlushE;
    logic             BranchTakenE;
    logic [31:0]      BranchTargetE;
    logic             PredRedirectD;
    logic [31:0]      PredTargetD;
    logic             MispredictE;
    logic [31:0]      CorrectPCE;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] MispredCnt;

    int n_tests = 0;
    int n_fail  = 0;

    static_branch_predictor #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ValidD        (ValidD),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .ImmExtD       (ImmExtD),
        .StallE        (StallE),
        .FlushE        (FlushE),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .PredRedirectD (PredRedirectD),
        .PredTargetD   (PredTargetD),
        .MispredictE   (MispredictE),
        .CorrectPCE    (CorrectPCE),
        .BranchCnt     (BranchCnt),
        .MispredCnt    (MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm);
        ValidD  = v;
        InstrD  = instr;
        PCD     = pc;
        ImmExtD = imm;
    endtask

    task automatic set_e(input logic taken, input logic [31:0] target);
        BranchTakenE  = taken;
        BranchTargetE = target;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int bc, input int mc);
        check({tag, "_bcnt"}, 32'(BranchCnt), 32'(bc));
        check({tag, "_mcnt"}, 32'(MispredCnt), 32'(mc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        set_e(1'b0, 32'h0);
        #2;
        // Reset state
        check("rst_mispred", 32'(MispredictE), 32'd0);
        check("rst_correct_pc4", CorrectPCE, 32'h0);
        check("rst_redirect", 32'(PredRedirectD), 32'd0);
        check_cnt("rst", 0, 0);
        set_e(1'b1, 32'h0000_1234);
        #1;
        check("rst_correct_tgt", CorrectPCE, 32'h0000_1234);
        // Target wraps modulo 2^32
        set_d(1'b0, I_BEQ, 32'h0000_0004, 32'hFFFF_FFF8);
        #1;
        check("wrap_target", PredTargetD, 32'hFFFF_FFFC);
        set_e(1'b0, 32'h0);
        #8;
        rst_n = 1'b1;
        tick();

        // Backward BEQ predicted taken
        set_d(1'b1, I_BEQ, 32'h0000_0100, 32'hFFFF_FFFC);
        #1;
        check("beq_redirect", 32'(PredRedirectD), 32'd1);
        check("beq_target", PredTargetD, 32'h0000_00FC);
        tick();
        // BEQ resolves taken to 0xFC; forward BNE in decode
        set_d(1'b1, I_BNE, 32'h0000_0200, 32'h0000_0010);
        set_e(1'b1, 32'h0000_00FC);
        #1;
        check("beq_mispred", 32'(MispredictE), 32'd0);
        check("bne_redirect", 32'(PredRedirectD), 32'd0);
        tick();
        check_cnt("beq", 1, 0);

        // Forward BNE resolves taken: mispredict
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        set_e(1'b1, 32'h0000_0210);
        #1;
        check("bne_mispred", 32'(MispredictE), 32'd1);
        check("bne_correct_pc", CorrectPCE, 32'h0000_0210);
        tick();
        check_cnt("bne", 2, 1);
        // Record squashed: no mispredict despite a mismatching outcome
        set_e(1'b1, 32'h0000_0999);
        set_d(1'b1, I_BEQ, 32'h0000_0300, 32'hFFFF_FFF0);
        #1;
        check("bne_squashed", 32'(MispredictE), 32'd0);
        check("b300_redirect", 32'(PredRedirectD), 32'd1);
        tick();
        check_cnt("squash", 2, 1);

        // Predicted-taken branch at 0x300 resolves not-taken; JAL in decode
        set_d(1'b1, I_JAL, 32'h0000_0500, 32'h0000_0100);
        set_e(1'b0, 32'h0);
        #1;
        check("b300_mispred", 32'(MispredictE), 32'd1);
        check("b300_correct_pc", CorrectPCE, 32'h0000_0304);
        check("jal_suppressed", 32'(PredRedirectD), 32'd0);
        tick();
        check_cnt("b300", 3, 2);
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        set_e(1'b1, 32'h0000_0600);
        #1;
        check("jal_wrongpath_dropped", 32'(MispredictE), 32'd0);

        // JAL at 0x400
        set_d(1'b1, I_JAL, 32'h0000_0400, 32'h0000_0800);
        #1;
        check("jal_redirect", 32'(PredRedirectD), 32'd1);
        check("jal_target", PredTargetD, 32'h0000_0C00);
        tick();
        set_d(1'b1, I_JALR, 32'h0000_0600, 32'hFFFF_FFF0);
        set_e(1'b1, 32'h0000_0C00);
        #1;
        check("jal_mispred", 32'(MispredictE), 32'd0);
        check("jalr_redirect", 32'(PredRedirectD), 32'd0);
        tick();
        check_cnt("jal", 3, 2);
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        set_e(1'b1, 32'h0000_0123);
        #1;
        check("jalr_no_record", 32'(MispredictE), 32'd0);
        tick();
        check_cnt("jalr", 3, 2);

        // Stall with a mispredicting record
        set_d(1'b1, I_BNE, 32'h0000_0700, 32'h0000_0020);
        set_e(1'b0, 32'h0);
        tick();
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        set_e(1'b1, 32'h0000_0720);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mispred", 32'(MispredictE), 32'd0);
            tick();
            check_cnt("stall", 3, 2);
        end
        StallE = 1'b0;
        #1;
        check("release_mispred", 32'(MispredictE), 32'd1);
        check("release_correct_pc", CorrectPCE, 32'h0000_0720);
        tick();
        check_cnt("release", 4, 3);
        check("release_single_pulse", 32'(MispredictE), 32'd0);
        tick();
        check_cnt("release_once", 4, 3);

        // Flush a branch entering EX
        set_d(1'b1, I_BEQ, 32'h0000_0800, 32'hFFFF_FF00);
        set_e(1'b0, 32'h0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("flush_mispred", 32'(MispredictE), 32'd0);
        tick();
        check_cnt("flush", 4, 3);

        // Stream of correctly predicted backward branches to saturate BranchCnt
        set_d(1'b1, I_BEQ, 32'h0000_0900, 32'hFFFF_FFFC);
        set_e(1'b1, 32'h0000_08FC);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check_cnt("sat", 15, 3);
        tick();
        check_cnt("sat_hold", 15, 3);

        // Asynchronous reset mid-stream with a mispredicting record in EX
        set_e(1'b0, 32'h0);
        #1;
        check("pre_rst_mispred", 32'(MispredictE), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mispred", 32'(MispredictE), 32'd0);
        check_cnt("async_rst", 0, 0);
        set_d(1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_redirect", 32'(PredRedirectD), 32'd0);
        set_e(1'b1, 32'h0000_0ABC);
        tick();
        check("post_rst_mispred", 32'(MispredictE), 32'd0);
        check_cnt("post_rst", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/static_branch_predictor.md
Name: static_branch_predictor

Overview:
- Decode-stage static predictor for the 5-stage RISC-V pipeline.
- Consumes the decoded instruction, its PC and the sign-extended B/J immediate from the immediate extension unit.
- Applies backward-taken/forward-not-taken (BTFN) prediction for conditional branches and always-taken for JAL, and redirects fetch from decode.
- Carries each prediction record into EX, checks it against the ALU branch outcome, raises the mispredict redirect, and keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- ValidD  input  1  decode slot holds a real instruction
- InstrD  input  32  instruction in decode
- PCD  input  32  PC of InstrD
- ImmExtD  input  32  B-type or J-type immediate (sign-extended, bit 0 = 0) from the extension unit
- StallE  input  1  hold the EX record
- FlushE  input  1  hazard-unit bubble into EX
- BranchTakenE  input  1  actual outcome of the control instruction in EX (JAL reports 1)
- BranchTargetE  input  32  actual target computed in EX
- PredRedirectD  output  1  fetch must go to PredTargetD next cycle
- PredTargetD  output  32  PCD + ImmExtD, mod 2^32
- MispredictE  output  1  EX record was mispredicted
- CorrectPCE  output  32  recovery fetch address
- BranchCnt  output  CNT_W  resolved conditional branches
- MispredCnt  output  CNT_W  mispredicted conditional branches

Behaviour:
- Opcode decode on InstrD[6:0]:
  - 1100011 = conditional branch.
  - 1101111 = JAL.
  - All others, including JALR, are not predicted: no redirect, no record.
- Decode prediction (combinational):
  - PredTakenD = ValidD & (JAL | (branch & ImmExtD[31])).
  - PredRedirectD = PredTakenD & ~MispredictE. EX redirect always wins, because the decode instruction is then wrong-path.
  - PredTargetD is always driven and wraps modulo 2^32. Example: PCD 0x0000_0004 + ImmExtD 0xFFFF_FFF8 = 0xFFFF_FFFC.
- EX record, loaded at the clk rising edge. Fields: ValidE, IsBranchE, PredTakenE, PredTargetE, PCPlus4E = PCD + 4.
  - Priority 1, rst_n low: all fields cleared, asynchronously.
  - Priority 2, MispredictE or FlushE: ValidE <= 0.
  - Priority 3, StallE: hold.
  - Otherwise: load. ValidE <= ValidD & (branch | JAL).
  - StallE together with MispredictE: the flush wins.
- EX check (combinational on the record):
  - MispredictE = ValidE & ~StallE & ((BranchTakenE != PredTakenE) | (BranchTakenE & BranchTargetE != PredTargetE)).
  - CorrectPCE = BranchTakenE ? BranchTargetE : PCPlus4E.
  - MispredictE is 0 whenever ValidE is 0, whatever the other inputs are.
- Counters, updated on edges where ValidE & IsBranchE & ~StallE:
  - BranchCnt += 1.
  - MispredCnt += 1 if MispredictE.
  - Both saturate at all-ones with no wrap.
  - JAL records are never counted.
- Latency:
  - Decode redirect takes effect in the same cycle (combinational).
  - Mispredict is flagged in the cycle the record is in EX and unstalled; its record is invalid the next cycle.
- Reset values: the EX record and both counters are 0. Consequently MispredictE = 0, and CorrectPCE follows BranchTakenE / BranchTargetE (PCPlus4E = 0).
- Reset mid-operation: all state is cleared immediately. No redirect is pending after release.

Test Plan:
- Backward BEQ: PCD 0x100, InstrD 0xFE000EE3, ImmExtD 0xFFFFFFFC, ValidD 1 -> PredRedirectD 1, PredTargetD 0x0FC. Next cycle BranchTakenE 1, BranchTargetE 0x0FC -> MispredictE 0; BranchCnt 1, MispredCnt 0.
- Forward BNE: PCD 0x200, ImmExtD 0x10 -> PredRedirectD 0. Next cycle BranchTakenE 1, BranchTargetE 0x210 -> MispredictE 1, CorrectPCE 0x210; MispredCnt 1; ValidE 0 the following cycle.
- Predicted-taken backward branch resolved not-taken, with PCD 0x300 -> MispredictE 1, CorrectPCE 0x304. Simultaneous JAL in decode -> PredRedirectD 0.
- JAL at PCD 0x400, ImmExtD 0x800 -> PredRedirectD 1, PredTargetD 0xC00. JALR in decode -> no redirect, ValidE 0. Counters unchanged in both cases.
- StallE held 3 cycles with a mispredicting record -> MispredictE 0 and counters frozen. Release -> a single MispredictE pulse and a single increment. FlushE with the record in EX -> ValidE 0, no counting.
- Counters forced near saturation via 2^CNT_W-1 branches (CNT_W=4 build: 15 branches) -> BranchCnt stays 0xF. rst_n pulled low mid-stream -> counters 0 and MispredictE 0 asynchronously, before the next edge.
